// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters with registered, mutually
// aligned coordinate, valid, sync and marker outputs.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_ACTIVE  = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic        pix_en,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        valid_q, valid_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        pix_en_q;
  logic        h_wrap;
  logic        v_wrap;
  logic        act;
  logic        in_hs;
  logic        in_vs;

  // Next raster position; frame counter bumps on full-frame wrap
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    fcnt_d   = fcnt_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      if (v_wrap) begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Decode of the current (pre-increment) position
  always_comb begin
    act     = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    in_hs   = (hcount_q >= HS_BEG) && (hcount_q < HS_END);
    in_vs   = (vcount_q >= VS_BEG) && (vcount_q < VS_END);
    valid_d = act;
    x_d     = act ? hcount_q : 11'd0;
    y_d     = act ? vcount_q[9:0] : 10'd0;
    hsync_d = in_hs ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = in_vs ? VSYNC_POL : ~VSYNC_POL;
    ls_d    = (hcount_q == 11'd0);
    fs_d    = (hcount_q == 11'd0) && (vcount_q == 11'd0);
  end

  // State and output registers; everything but pix_en holds on en=0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      fcnt_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      pix_en_q <= 1'b0;
    end else begin
      pix_en_q <= en;
      if (en) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        fcnt_q   <= fcnt_d;
        x_q      <= x_d;
        y_q      <= y_d;
        valid_q  <= valid_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        ls_q     <= ls_d;
        fs_q     <= fs_d;
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign pix_en      = pix_en_q;
  assign frame_count = fcnt_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing generator that drives the pixel-stream interface consumed by the waveform display path: x, y, valid, vsync, plus hsync for the video PHY.
- Owns the horizontal and vertical counters for a configurable mode; the default is VESA 1280x1024@60 at a 108 MHz pixel rate.
- A pixel-enable input lets it run from a faster system clock.
- All outputs are registered and mutually aligned, so downstream blocks see a clean, glitch-free raster.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 48, horizontal front porch (pixels)
H_SYNC, 112, hsync width (pixels)
H_BP, 248, horizontal back porch (pixels); H_TOTAL = sum = 1688
V_ACTIVE, 1024, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 38, vertical back porch (lines); V_TOTAL = sum = 1066
HSYNC_POL, 1, asserted level of hsync
VSYNC_POL, 1, asserted level of vsync

Ports:
clk  in  1  system/pixel clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
en  in  1  pixel enable; counters advance only on clk edges with en=1
x  out  11  pixel column 0..H_ACTIVE-1 while valid, else 0
y  out  10  pixel row 0..V_ACTIVE-1 while valid, else 0
valid  out  1  current pixel is inside the active area
hsync  out  1  horizontal sync at HSYNC_POL level during the sync interval
vsync  out  1  vertical sync at VSYNC_POL level during the sync interval
line_start  out  1  high for the output pixel at hcount=0 of any line
frame_start  out  1  high for the output pixel at hcount=0, vcount=0
pix_en  out  1  registered en; marks cycles where outputs were updated
frame_count  out  8  completed-frame counter, wraps 255->0

Behaviour:
Reset values:
- hcount=0, vcount=0, x=0, y=0, valid=0.
- hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- line_start=0, frame_start=0, pix_en=0, frame_count=0.
- Reset assertion mid-frame takes effect immediately and asynchronously; all outputs return to these values.

Counters:
- Internal hcount is 11 bits (0..H_TOTAL-1); vcount is 11 bits (0..V_TOTAL-1).
- On a clk edge with en=1: hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments. At vcount=V_TOTAL-1 with hcount=H_TOTAL-1, both wrap to 0 and frame_count increments.

Output pipeline (one-cycle latency):
- On a clk edge with en=1, the output registers load the decode of the pre-increment counter values.
- valid = (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
- x = valid ? hcount : 0.
- y = valid ? vcount[9:0] : 0.
- hsync asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, evaluated on vcount only, so it is whole-line aligned.
- line_start = (hcount==0).
- frame_start = (hcount==0 && vcount==0).
- First en edge after reset release: outputs show x=0, y=0, valid=1, frame_start=1, line_start=1.

Enable handling:
- en=0 edge: counters and all outputs except pix_en hold their values; pix_en <= 0.
- en=1 edge: pix_en <= 1.
- Consumers qualify line_start and frame_start with pix_en.

Invariants:
- No partial lines or frames.
- hsync and vsync are never asserted while valid=1.
- frame_start implies line_start.

Test Plan:
- Small mode (H 8/2/3/3 → H_TOTAL=16; V 4/1/2/1 → V_TOTAL=8), en=1, release reset at cycle 0 → first output cycle has x=0, y=0, valid=1, frame_start=1; frame_start recurs exactly every 128 cycles; frame_count=3 after 384 cycles.
- Small mode, one line → valid high for 8 cycles with x=0..7; hsync asserted for 3 cycles at hcount 10..12; line_start every 16 cycles.
- Small mode, full frame → vsync asserted for exactly 32 consecutive cycles (vcount 5..6); valid=0 and y=0 throughout; vsync and valid never both high.
- en toggling 1,0,0,1 repeatedly → outputs change only after en=1 edges; pix_en mirrors en one cycle late; the raster sequence is identical to the en=1 run.
- Assert reset at x=5, y=2 for 1 cycle, then release → outputs immediately go to reset values (hsync=0, vsync=0 with default POL=1); next en edge restarts at (0,0) with frame_start=1.
- Default params, run 1688*1066 cycles → exactly 1 frame_start per frame, 1280*1024 valid cycles, max x=1279, max y=1023, frame_count=1.
